// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between fetch_unit (master) and the memory (slave).
// mem_rd holds high for the whole request; the master samples mem_rdata on the posedge where mem_rdy=1.
interface fetch_unit_if;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rdy;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata,
        input  mem_rdy
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata,
        output mem_rdy
    );
endinterface

// File: rtl/fetch_unit.sv
// LC-3 instruction-fetch stage: owns PC and IR, reads instruction memory through a
// ready handshake, and aborts with a one-cycle fetch_err if memory stalls too long.
module fetch_unit #(
    parameter logic [15:0] PC_RESET = 16'h3000,
    parameter int          TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ld_pc,
    input  logic               pcmux,
    input  logic [15:0]        from_bus,
    input  logic [15:0]        pc_target,
    fetch_unit_if.master       mem,
    output logic [15:0]        pc,
    output logic [15:0]        ir,
    output logic               ir_valid,
    output logic               busy,
    output logic               fetch_err,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT);
    localparam logic [7:0] TO_PREV = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_pc;
    logic [15:0] r_ir;

    state_t      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_ir_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_pc    <= PC_RESET;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    // A timeout parks the counter at TIMEOUT for one IDLE cycle; that is the fetch_err pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 8'd0;
                if (ld_pc) begin
                    w_pc_nxt = pcmux ? pc_target : from_bus;
                end
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem.mem_rdy) begin
                    w_ir_nxt    = mem.mem_rdata;
                    w_pc_nxt    = r_pc + 16'd1;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == TO_PREV) begin
                    w_cnt_nxt   = TO_LAST;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem.mem_rd   = (r_state == S_FETCH);
    assign mem.mem_addr = r_pc;
    assign pc           = r_pc;
    assign ir           = r_ir;
    assign ir_valid     = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign fetch_err    = (r_state == S_IDLE) && (r_cnt == TO_LAST);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait and wait-state fetches, timeout,
// PC load/wrap, ignored requests and asynchronous reset during a fetch.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ld_pc;
  logic        pcmux;
  logic [15:0] from_bus;
  logic [15:0] pc_target;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        ir_valid;
  logic        busy;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  fetch_unit_if mem_if ();

  fetch_unit #(
    .PC_RESET (16'h3000),
    .TIMEOUT  (15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ld_pc     (ld_pc),
    .pcmux     (pcmux),
    .from_bus  (from_bus),
    .pc_target (pc_target),
    .mem       (mem_if),
    .pc        (pc),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .busy      (busy),
    .fetch_err (fetch_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    ld_pc           = 1'b0;
    pcmux           = 1'b0;
    from_bus        = 16'h0000;
    pc_target       = 16'h0000;
    mem_if.mem_rdy  = 1'b0;
    mem_if.mem_rdata = 16'h0000;
    tick();
    tick();

    // reset state
    check("rst_pc", pc, 16'h3000);
    check("rst_ir", ir, 16'h0000);
    check("rst_mem_rd", {15'd0, mem_if.mem_rd}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
    check("rst_fetch_err", {15'd0, fetch_err}, 16'd0);
    reset = 1'b0;
    tick();

    // zero-wait fetch
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_if.mem_rdy   = 1'b1;
    mem_if.mem_rdata = 16'h1262;
    check("zw_mem_rd", {15'd0, mem_if.mem_rd}, 16'd1);
    check("zw_addr", mem_if.mem_addr, 16'h3000);
    check("zw_busy", {15'd0, busy}, 16'd1);
    tick();
    mem_if.mem_rdy = 1'b0;
    check("zw_ir", ir, 16'h1262);
    check("zw_pc", pc, 16'h3001);
    check("zw_ir_valid", {15'd0, ir_valid}, 16'd1);
    check("zw_rd_done", {15'd0, mem_if.mem_rd}, 16'd0);
    tick();
    check("zw_ir_valid_end", {15'd0, ir_valid}, 16'd0);
    check("zw_idle", {15'd0, busy}, 16'd0);
    check("zw_ir_hold", ir, 16'h1262);

    // three wait states
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ws_mem_rd", {15'd0, mem_if.mem_rd}, 16'd1);
      check("ws_addr", mem_if.mem_addr, 16'h3001);
      tick();
    end
    mem_if.mem_rdy   = 1'b1;
    mem_if.mem_rdata = 16'h5020;
    check("ws_mem_rd_last", {15'd0, mem_if.mem_rd}, 16'd1);
    check("ws_addr_last", mem_if.mem_addr, 16'h3001);
    tick();
    mem_if.mem_rdy = 1'b0;
    check("ws_mem_rd_off", {15'd0, mem_if.mem_rd}, 16'd0);
    check("ws_ir", ir, 16'h5020);
    check("ws_pc", pc, 16'h3002);
    check("ws_ir_valid", {15'd0, ir_valid}, 16'd1);
    check("ws_no_err", {15'd0, fetch_err}, 16'd0);
    tick();
    check("ws_no_err_idle", {15'd0, fetch_err}, 16'd0);

    // timeout after 15 FETCH edges
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      check("to_mem_rd", {15'd0, mem_if.mem_rd}, 16'd1);
      check("to_err_early", {15'd0, fetch_err}, 16'd0);
      tick();
    end
    check("to_err", {15'd0, fetch_err}, 16'd1);
    check("to_busy", {15'd0, busy}, 16'd0);
    check("to_mem_rd_off", {15'd0, mem_if.mem_rd}, 16'd0);
    check("to_ir_valid", {15'd0, ir_valid}, 16'd0);
    check("to_pc", pc, 16'h3002);
    check("to_ir", ir, 16'h5020);
    tick();
    check("to_err_pulse", {15'd0, fetch_err}, 16'd0);

    // ld_pc from bus together with start, PC wraps
    ld_pc    = 1'b1;
    pcmux    = 1'b0;
    from_bus = 16'hFFFF;
    start    = 1'b1;
    tick();
    ld_pc = 1'b0;
    start = 1'b0;
    check("wr_pc", pc, 16'hFFFF);
    check("wr_addr", mem_if.mem_addr, 16'hFFFF);
    check("wr_mem_rd", {15'd0, mem_if.mem_rd}, 16'd1);
    mem_if.mem_rdy   = 1'b1;
    mem_if.mem_rdata = 16'hABCD;
    tick();
    mem_if.mem_rdy = 1'b0;
    check("wr_pc_wrap", pc, 16'h0000);
    check("wr_ir", ir, 16'hABCD);
    tick();

    // ld_pc from target adder
    ld_pc     = 1'b1;
    pcmux     = 1'b1;
    pc_target = 16'h4010;
    from_bus  = 16'h1111;
    tick();
    ld_pc = 1'b0;
    check("tg_pc", pc, 16'h4010);
    check("tg_busy", {15'd0, busy}, 16'd0);

    // ld_pc and start ignored during FETCH
    start = 1'b1;
    tick();
    start    = 1'b1;
    ld_pc    = 1'b1;
    pcmux    = 1'b0;
    from_bus = 16'h1234;
    tick();
    start = 1'b0;
    ld_pc = 1'b0;
    check("ig_pc", pc, 16'h4010);
    check("ig_mem_rd", {15'd0, mem_if.mem_rd}, 16'd1);
    mem_if.mem_rdy   = 1'b1;
    mem_if.mem_rdata = 16'h2345;
    tick();
    mem_if.mem_rdy = 1'b0;
    check("ig_pc_adv", pc, 16'h4011);
    check("ig_ir", ir, 16'h2345);
    tick();
    check("ig_idle", {15'd0, busy}, 16'd0);
    tick();
    check("ig_no_second", {15'd0, busy}, 16'd0);
    check("ig_pc_hold", pc, 16'h4011);

    // mem_rdy outside FETCH ignored
    mem_if.mem_rdy   = 1'b1;
    mem_if.mem_rdata = 16'hFFFF;
    tick();
    mem_if.mem_rdy = 1'b0;
    check("rd_idle_ir", ir, 16'h2345);
    check("rd_idle_valid", {15'd0, ir_valid}, 16'd0);

    // asynchronous reset mid-fetch
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mr_waiting", {15'd0, mem_if.mem_rd}, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_mem_rd", {15'd0, mem_if.mem_rd}, 16'd0);
    check("mr_pc", pc, 16'h3000);
    check("mr_ir", ir, 16'h0000);
    check("mr_busy", {15'd0, busy}, 16'd0);
    check("mr_ir_valid", {15'd0, ir_valid}, 16'd0);
    mem_if.mem_rdy   = 1'b1;
    mem_if.mem_rdata = 16'h0F0F;
    tick();
    check("mr_hold_valid", {15'd0, ir_valid}, 16'd0);
    check("mr_hold_ir", ir, 16'h0000);
    reset          = 1'b0;
    mem_if.mem_rdy = 1'b0;
    tick();
    check("mr_after_valid", {15'd0, ir_valid}, 16'd0);
    check("mr_after_busy", {15'd0, busy}, 16'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the LC-3 datapath, directly upstream of `processing_unit`. It holds the PC and issues read requests to instruction memory through a ready-based handshake. It captures the returned word into the IR, whose fields (`ir[11:9]`, `ir[8:6]`, `ir[5]`, `ir[4:0]`, `ir[2:0]`) drive `processing_unit` directly. It also loads new PC values from the bus or from a branch-target adder.

## Interface
- `PC_RESET`, 16'h3000, PC value after reset.
- `TIMEOUT`, 15, maximum cycles in FETCH awaiting `mem_rdy` before abort; legal range 1–255.

- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request one instruction fetch; sampled only in IDLE.
- `ld_pc`  in  1  load PC from the source chosen by `pcmux`; honoured only in IDLE.
- `pcmux`  in  1  PC load source: 0 = `from_bus`, 1 = `pc_target`.
- `from_bus`  in  16  shared datapath bus (JMP/RET target).
- `pc_target`  in  16  PC+offset adder result (BR/JSR target).
- `mem_rdata`  in  16  instruction memory read data; valid when `mem_rdy`=1.
- `mem_rdy`  in  1  memory read completion.
- `mem_rd`  out  1  read request; high for the whole FETCH state.
- `mem_addr`  out  16  read address; equals `pc`, stable while `mem_rd`=1.
- `pc`  out  16  current PC.
- `ir`  out  16  instruction register.
- `ir_valid`  out  1  one-cycle pulse after a successful IR load.
- `busy`  out  1  high in any state other than IDLE.
- `fetch_err`  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, FETCH, DONE. The wait counter is 8 bits wide.
- **IDLE**
  - `ld_pc`=1: `pc` loads `pcmux ? pc_target : from_bus`.
  - `start`=1: go to FETCH and clear the wait counter.
  - Both asserted in the same cycle: both take effect. The fetch uses the newly loaded PC.
- **FETCH**
  - `mem_rd`=1 and `mem_addr`=`pc` throughout.
  - Posedge with `mem_rdy`=1: `ir` <= `mem_rdata`, `pc` <= `pc`+1 (16-bit modulo; 16'hFFFF wraps to 16'h0000), go to DONE.
  - Posedge with `mem_rdy`=0: counter increments.
  - Counter reaches `TIMEOUT` with `mem_rdy` still 0: go to IDLE and pulse `fetch_err`. `pc` and `ir` are unchanged.
  - `mem_rdy` takes priority over timeout on the same edge.
- **DONE:** `ir_valid`=1 for exactly one cycle, then IDLE.
- `ld_pc` outside IDLE is ignored. `start` outside IDLE is ignored; it is not queued.
- `mem_rdy` while not in FETCH is ignored.
- `ir` holds its value between fetches. Only a successful fetch changes it.

## Timing
- Reset values (asynchronous; apply immediately, including mid-fetch):
  - state = IDLE
  - `pc` = `PC_RESET`, `ir` = 16'h0000
  - `mem_rd` = 0, `ir_valid` = 0, `busy` = 0, `fetch_err` = 0
  - counter = 0
- `mem_addr` is combinational from `pc`.
- `mem_rd`, `busy`, `ir_valid` and `fetch_err` are decoded from state and counter only; there is no combinational path from inputs to outputs.
- Zero-wait memory (`mem_rdy`=1 in the first FETCH cycle):
  - `start` sampled at edge N.
  - FETCH during cycle N..N+1; IR and PC update at edge N+1.
  - `ir_valid` high during cycle N+1..N+2.
  - Earliest next `start` is sampled at edge N+3.
- Each wait cycle adds one cycle of latency.
- Timeout: `fetch_err` is high for the one cycle after the edge on which the counter would reach `TIMEOUT`. That is edge N+`TIMEOUT`, counting the first FETCH edge as N+1.
- `ir` is stable from the DONE cycle onward, so `processing_unit` may use `ir` fields in the same cycle `ir_valid` is high.

## Test plan
- **Reset then fetch, zero-wait:**
  - Stimulus: reset; `start`; `mem_rdy`=1 with `mem_rdata`=16'h1262 (ADD R1,R1,#2).
  - Expect `mem_addr`=16'h3000 during FETCH.
  - Expect `ir`=16'h1262, `pc`=16'h3001, one `ir_valid` pulse.
- **Wait states:**
  - Stimulus: hold `mem_rdy`=0 for 3 cycles, then 1 with 16'h5020.
  - Expect `mem_rd` high for exactly 4 cycles and `mem_addr` stable.
  - Expect `ir`=16'h5020, no `fetch_err`.
- **Timeout:**
  - Stimulus: `mem_rdy` held 0 with `TIMEOUT`=15.
  - Expect `fetch_err` pulse after 15 FETCH edges, return to IDLE.
  - Expect `pc` and `ir` unchanged.
- **PC load and wrap:**
  - `ld_pc`, `pcmux`=0, `from_bus`=16'hFFFF, together with `start`: expect fetch at 16'hFFFF, `pc` wraps to 16'h0000.
  - `ld_pc`, `pcmux`=1, `pc_target`=16'h4010: expect `pc`=16'h4010.
- **Ignored requests:** pulse `ld_pc` (`from_bus`=16'h1234) and `start` during FETCH. Expect the PC to advance only by the fetch and no second fetch to occur.
- **Reset mid-fetch:** assert `reset` while FETCH is waiting. Expect `mem_rd` to drop immediately, `pc`=16'h3000, `ir`=16'h0000, and no `ir_valid`.
